// File: rtl/pixel_seq_pkg.sv
// Shared definitions for the pixel frame sequencer.
//   state_t   : sequencer phase encoding
//   GAP_CYC   : length of the quiet cycle inserted after every active phase
//   bin2gray  : binary to Gray conversion used for the ADC ramp count
package pixel_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ERASE,
    ST_EXPOSE,
    ST_CONVERT,
    ST_READ,
    ST_GAP
  } state_t;

  localparam int unsigned GAP_CYC = 1;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/pixel_frame_seq_timer.sv
// phase_timer: loadable down-counter timing each sequencer phase.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   load       : load load_val and arm the timer
//   load_val   : phase length minus one
//   done       : high for one cycle when the armed count reaches zero
//   count      : current count value
module phase_timer #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done,
  output logic [W-1:0] count
);

  logic armed;

  assign done = armed && (count == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      armed <= 1'b0;
    end else if (load) begin
      count <= load_val;
      armed <= 1'b1;
    end else if (done) begin
      armed <= 1'b0;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

endmodule

// File: rtl/pixel_frame_seq.sv
// pixel_frame_seq: frame sequencer for the pixel array.
// Drives erase -> expose -> convert -> NUM_ROWS reads, each followed by a
// single quiet GAP cycle, generates a Gray-coded ADC ramp during convert and
// a capture strobe on the last cycle of each read.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   start       : frame request (accepted only when idle)
//   continuous  : restart automatically at frame end
//   abort       : synchronous stop (priority over start/continuous)
//   exp_time    : exposure length in clocks (0 treated as 1)
//   busy, frame_done, erase, expose, convert, read_sel, row_idx,
//   ramp_cnt, capture : registered sequencer outputs
//   frame_cnt   : completed-frame counter, present only when
//                 PIXEL_SEQ_STATUS_EN is defined
module pixel_frame_seq
  import pixel_seq_pkg::*;
#(
  parameter int unsigned ERASE_CYC = 5,
  parameter int unsigned READ_CYC  = 5,
  parameter int unsigned NUM_ROWS  = 4,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned EXP_W     = 16,
  localparam int unsigned RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                continuous,
  input  logic                abort,
  input  logic [EXP_W-1:0]    exp_time,
  output logic                busy,
  output logic                frame_done,
  output logic                erase,
  output logic                expose,
  output logic                convert,
  output logic [NUM_ROWS-1:0] read_sel,
  output logic [RW-1:0]       row_idx,
  output logic [CNT_W-1:0]    ramp_cnt,
  output logic                capture
`ifdef PIXEL_SEQ_STATUS_EN
  ,output logic [15:0]        frame_cnt
`endif
);

  localparam int unsigned TW = (EXP_W > CNT_W + 1) ? EXP_W : CNT_W + 1;

  state_t             state, state_nxt, last_ph, last_nxt;
  logic [RW-1:0]      row_nxt;
  logic [EXP_W-1:0]   exp_q, exp_nxt;
  logic [CNT_W-1:0]   ramp_bin, ramp_bin_nxt;
  logic               fdone_nxt;
  logic               t_load, t_done;
  logic [TW-1:0]      t_val, t_cnt;

  phase_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (t_load),
    .load_val (t_val),
    .done     (t_done),
    .count    (t_cnt)
  );

  // The phase that follows a GAP is chosen from the phase that preceded it
  // (last_ph), so a single GAP state serves every transition.
  always_comb begin
    state_nxt    = state;
    last_nxt     = last_ph;
    row_nxt      = row_idx;
    exp_nxt      = exp_q;
    fdone_nxt    = 1'b0;
    t_load       = 1'b0;
    t_val        = '0;
    ramp_bin_nxt = ramp_bin;
    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: if (start) begin
          state_nxt = ST_ERASE;
          t_load    = 1'b1;
          t_val     = TW'(ERASE_CYC - 1);
          exp_nxt   = exp_time;
        end
        ST_ERASE, ST_EXPOSE, ST_CONVERT, ST_READ: if (t_done) begin
          state_nxt = ST_GAP;
          last_nxt  = state;
          t_load    = 1'b1;
          t_val     = TW'(GAP_CYC - 1);
          if (state == ST_READ && row_idx == RW'(NUM_ROWS - 1))
            fdone_nxt = 1'b1;
        end
        ST_GAP: if (t_done) begin
          t_load = 1'b1;
          unique case (last_ph)
            ST_ERASE: begin
              state_nxt = ST_EXPOSE;
              t_val     = (exp_q == '0) ? '0 : TW'(exp_q - EXP_W'(1));
            end
            ST_EXPOSE: begin
              state_nxt = ST_CONVERT;
              t_val     = TW'((1 << CNT_W) - 1);
            end
            ST_CONVERT: begin
              state_nxt = ST_READ;
              row_nxt   = '0;
              t_val     = TW'(READ_CYC - 1);
            end
            ST_READ: begin
              if (row_idx == RW'(NUM_ROWS - 1)) begin
                if (continuous) begin
                  state_nxt = ST_ERASE;
                  t_val     = TW'(ERASE_CYC - 1);
                  exp_nxt   = exp_time;
                end else begin
                  state_nxt = ST_IDLE;
                  t_load    = 1'b0;
                end
              end else begin
                state_nxt = ST_READ;
                row_nxt   = row_idx + RW'(1);
                t_val     = TW'(READ_CYC - 1);
              end
            end
            default: begin
              state_nxt = ST_IDLE;
              t_load    = 1'b0;
            end
          endcase
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
    if (state_nxt == ST_ERASE && state != ST_ERASE)
      ramp_bin_nxt = '0;
    else if (state_nxt == ST_CONVERT)
      ramp_bin_nxt = (state == ST_CONVERT) ? ramp_bin + CNT_W'(1) : '0;
  end

  // Outputs are decoded from the next state so that every output is a flop
  // aligned with the state it describes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      last_ph    <= ST_IDLE;
      exp_q      <= '0;
      ramp_bin   <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      erase      <= 1'b0;
      expose     <= 1'b0;
      convert    <= 1'b0;
      read_sel   <= '0;
      row_idx    <= '0;
      ramp_cnt   <= '0;
      capture    <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_ph    <= last_nxt;
      exp_q      <= exp_nxt;
      ramp_bin   <= ramp_bin_nxt;
      busy       <= (state_nxt != ST_IDLE);
      frame_done <= fdone_nxt;
      erase      <= (state_nxt == ST_ERASE);
      expose     <= (state_nxt == ST_EXPOSE);
      convert    <= (state_nxt == ST_CONVERT);
      read_sel   <= (state_nxt == ST_READ) ? (NUM_ROWS'(1) << row_nxt) : '0;
      row_idx    <= row_nxt;
      ramp_cnt   <= CNT_W'(bin2gray(32'(ramp_bin_nxt)));
      // Count reaches zero on the following cycle, the last of the read.
      capture    <= (state_nxt == ST_READ) && (state == ST_READ) && (t_cnt == TW'(1));
    end
  end

`ifdef PIXEL_SEQ_STATUS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      frame_cnt <= '0;
    else if (fdone_nxt)
      frame_cnt <= frame_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_pixel_frame_seq.sv
module tb_pixel_frame_seq;

  localparam int unsigned ERASE_CYC = 5;
  localparam int unsigned READ_CYC  = 5;
  localparam int unsigned NUM_ROWS  = 4;
  localparam int unsigned CNT_W     = 8;
  localparam int unsigned EXP_W     = 16;
  localparam int unsigned RW        = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int unsigned RAMP      = 1 << CNT_W;

  logic                clk, reset, start, continuous, abort;
  logic [EXP_W-1:0]    exp_time;
  logic                busy, frame_done, erase, expose, convert, capture;
  logic [NUM_ROWS-1:0] read_sel;
  logic [RW-1:0]       row_idx;
  logic [CNT_W-1:0]    ramp_cnt;
`ifdef PIXEL_SEQ_STATUS_EN
  logic [15:0]         frame_cnt;
`endif

  pixel_frame_seq #(
    .ERASE_CYC (ERASE_CYC),
    .READ_CYC  (READ_CYC),
    .NUM_ROWS  (NUM_ROWS),
    .CNT_W     (CNT_W),
    .EXP_W     (EXP_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .continuous (continuous),
    .abort      (abort),
    .exp_time   (exp_time),
    .busy       (busy),
    .frame_done (frame_done),
    .erase      (erase),
    .expose     (expose),
    .convert    (convert),
    .read_sel   (read_sel),
    .row_idx    (row_idx),
    .ramp_cnt   (ramp_cnt),
    .capture    (capture)
`ifdef PIXEL_SEQ_STATUS_EN
    ,.frame_cnt (frame_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int unsigned cyc = 0;
  int unsigned base = 0;

  // Reference model: a frame is a timeline indexed by m_tf (1 = first erase
  // cycle); phase boundaries follow from the phase lengths by arithmetic.
  bit          m_in = 0;
  int unsigned m_tf = 0;
  int unsigned m_E = 1;
  int unsigned m_row = 0;
  int unsigned m_ramp = 0;
  int unsigned m_fc = 0;

  function automatic int unsigned gray(input int unsigned b);
    return b ^ (b >> 1);
  endfunction

  function automatic int unsigned eff(input logic [EXP_W-1:0] e);
    return (e == '0) ? 1 : int'(e);
  endfunction

  function automatic int unsigned frame_len(input int unsigned e);
    return ERASE_CYC + e + RAMP + NUM_ROWS * READ_CYC + NUM_ROWS + 3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_cycle();
    int unsigned x0, c0, rb, rs, off;
    logic e_busy, e_fd, e_erase, e_expose, e_conv, e_cap;
    logic [NUM_ROWS-1:0] e_sel;
    e_busy = 0; e_fd = 0; e_erase = 0; e_expose = 0; e_conv = 0; e_cap = 0;
    e_sel = '0;
    if (m_in) begin
      x0 = ERASE_CYC + 2;
      c0 = x0 + m_E + 1;
      rb = c0 + RAMP + 1;
      e_busy   = 1;
      e_erase  = (m_tf >= 1) && (m_tf <= ERASE_CYC);
      e_expose = (m_tf >= x0) && (m_tf < x0 + m_E);
      e_conv   = (m_tf >= c0) && (m_tf < c0 + RAMP);
      if (m_tf < c0) m_ramp = 0;
      else begin
        off = m_tf - c0;
        m_ramp = gray((off < RAMP - 1) ? off : RAMP - 1);
      end
      for (int unsigned k = 0; k < NUM_ROWS; k++) begin
        rs = rb + k * (READ_CYC + 1);
        if (m_tf >= rs) m_row = k;
        if (m_tf >= rs && m_tf < rs + READ_CYC) e_sel[k] = 1'b1;
        if (m_tf == rs + READ_CYC - 1) e_cap = 1'b1;
      end
      e_fd = (m_tf == frame_len(m_E));
      if (e_fd) m_fc = (m_fc + 1) & 32'hFFFF;
    end
    chk("busy", 32'(busy), 32'(e_busy));
    chk("frame_done", 32'(frame_done), 32'(e_fd));
    chk("erase", 32'(erase), 32'(e_erase));
    chk("expose", 32'(expose), 32'(e_expose));
    chk("convert", 32'(convert), 32'(e_conv));
    chk("read_sel", 32'(read_sel), 32'(e_sel));
    chk("capture", 32'(capture), 32'(e_cap));
    chk("row_idx", 32'(row_idx), m_row);
    chk("ramp_cnt", 32'(ramp_cnt), m_ramp);
`ifdef PIXEL_SEQ_STATUS_EN
    chk("frame_cnt", 32'(frame_cnt), m_fc);
`endif
  endtask

  task automatic tick();
    logic s_start, s_cont, s_abort;
    logic [EXP_W-1:0] s_exp;
    s_start = start; s_cont = continuous; s_abort = abort; s_exp = exp_time;
    @(posedge clk);
    #1;
    cyc++;
    if (s_abort) m_in = 0;
    else if (m_in && m_tf == frame_len(m_E)) begin
      if (s_cont) begin m_tf = 1; m_E = eff(s_exp); end
      else m_in = 0;
    end else if (m_in) m_tf++;
    else if (s_start) begin m_in = 1; m_tf = 1; m_E = eff(s_exp); end
    check_cycle();
  endtask

  task automatic run_to(input int unsigned rel);
    while (cyc - base < rel) tick();
  endtask

  task automatic begin_frame(input int unsigned e);
    base = cyc;
    exp_time = EXP_W'(e);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2000 && m_in; i++) tick();
    chk("wait_idle_timeout", 32'(m_in), 32'd0);
    tick();
  endtask

  initial begin
    reset = 1'b1; start = 0; continuous = 0; abort = 0; exp_time = '0;
    repeat (3) @(posedge clk);
    #1;
    check_cycle();
    @(negedge clk);
    reset = 1'b0;
    tick();

    // Nominal frame, exp_time=10
    begin_frame(10);
    run_to(18);  chk("ramp_c18", 32'(ramp_cnt), 32'd0);
    run_to(19);  chk("ramp_c19", 32'(ramp_cnt), 32'd1);
    run_to(20);  chk("ramp_c20", 32'(ramp_cnt), 32'd3);
    run_to(21);  chk("ramp_c21", 32'(ramp_cnt), 32'd2);
    run_to(273); chk("ramp_c273", 32'(ramp_cnt), 32'h80);
    run_to(279); chk("capture_c279", 32'(capture), 32'd1);
    run_to(298); chk("frame_done_c298", 32'(frame_done), 32'd1);
    run_to(299); chk("busy_c299", 32'(busy), 32'd0);
    tick();

    // exp_time=0 behaves as 1
    begin_frame(0);
    run_to(7);   chk("expose0_c7", 32'(expose), 32'd1);
    run_to(8);   chk("expose0_c8", 32'(expose), 32'd0);
    run_to(289); chk("frame_done_c289", 32'(frame_done), 32'd1);
    run_to(290); chk("busy_c290", 32'(busy), 32'd0);
`ifdef PIXEL_SEQ_STATUS_EN
    chk("frame_cnt_two", 32'(frame_cnt), 32'd2);
`endif
    tick();

    // Abort inside convert, then fresh start
    begin_frame(10);
    run_to(100);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_convert", 32'(convert), 32'd0);
    run_to(105);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_erase", 32'(erase), 32'd1);
    wait_idle();

    // Continuous mode with exposure change and an ignored start
    continuous = 1'b1;
    begin_frame(10);
    run_to(50);
    start = 1'b1;
    tick();
    start = 1'b0;
    run_to(150);
    exp_time = EXP_W'(20);
    run_to(299);
    chk("cont_erase_c299", 32'(erase), 32'd1);
    chk("cont_busy_c299", 32'(busy), 32'd1);
    continuous = 1'b0;
    run_to(324); chk("cont_expose_c324", 32'(expose), 32'd1);
    run_to(325); chk("cont_expose_c325", 32'(expose), 32'd0);
    wait_idle();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 19) == 0);
      abort = ($urandom_range(0, 699) == 0);
      if ($urandom_range(0, 99) == 0) continuous = ~continuous;
      exp_time = EXP_W'($urandom_range(0, 40));
      tick();
    end
    start = 0; abort = 0; continuous = 0;
    wait_idle();

    // Asynchronous reset during READ(1)
    begin_frame(10);
    run_to(283);
    #1;
    reset = 1'b1;
    #1;
    m_in = 0; m_row = 0; m_ramp = 0; m_fc = 0;
    check_cycle();
    @(negedge clk);
    reset = 1'b0;
    repeat (3) tick();

`ifdef PIXEL_SEQ_STATUS_EN
    force dut.frame_cnt = 16'hFFFF;
    #1;
    release dut.frame_cnt;
    m_fc = 32'hFFFF;
    begin_frame(3);
    wait_idle();
    chk("frame_cnt_wrap", 32'(frame_cnt), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
